// File: rtl/tge_tx_arbiter_pkg.sv
// Shared constants for the TGE transmit arbiter: FSM encoding and TGE field widths.
package tge_tx_arbiter_pkg;
   localparam int WORD_W = 64;
   localparam int IP_W   = 32;
   localparam int PORT_W = 16;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;
endpackage

// File: rtl/tge_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first requester found after 'last', wrapping.
module rr_select
   import tge_tx_arbiter_pkg::*;
#(
   parameter int N_SRC = 4
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [N_SRC-1:0] grant,
   output logic [IDX_W-1:0] idx
);
   always_comb begin
      int   pos;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         pos = (int'(last) + k) % N_SRC;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = IDX_W'(pos);
         end
      end
   end
endmodule

// File: rtl/tge_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one TGE transmit port; IDLE -> SEND -> GAP.
module tge_tx_arbiter
   import tge_tx_arbiter_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int CNT_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_SRC*64-1:0]     src_data,
   input  logic [N_SRC-1:0]        src_valid,
   input  logic [N_SRC-1:0]        src_eof,
   input  logic [N_SRC*32-1:0]     src_dest_ip,
   input  logic [N_SRC*16-1:0]     src_dest_port,
   output logic [N_SRC-1:0]        src_ready,
   input  logic [N_SRC-1:0]        src_enable,
   input  logic [CNT_WIDTH-1:0]    gap_cycles,
   input  logic                    tx_afull,
   output logic [63:0]             tx_data,
   output logic                    tx_valid,
   output logic                    tx_eof,
   output logic [31:0]             tx_dest_ip,
   output logic [15:0]             tx_dest_port,
   output logic [2:0]              grant_id,
   output logic [CNT_WIDTH-1:0]    pkt_count,
   output logic [1:0]              fsm_state
);
   // Source handshake: a beat moves on a clock edge where src_valid[i] and
   // src_ready[i] are both high; src_ready depends only on registered state.
   state_t                 state, next_state;
   logic [N_SRC-1:0]       req, rr_grant;
   logic [IDX_W-1:0]       rr_idx, ptr;
   logic [WORD_W-1:0]      sel_data;
   logic                   sel_valid, sel_eof;
   logic [IP_W-1:0]        req_ip;
   logic [PORT_W-1:0]      req_port;
   logic                   grant_now, accept;
   logic [CNT_WIDTH-1:0]   gap_cnt, gap_next;

   assign req       = src_valid & src_enable;
   assign gap_next  = gap_cnt + CNT_WIDTH'(1);
   assign fsm_state = state;

   rr_select #(.N_SRC(N_SRC)) u_rr (
      .req   (req),
      .last  (ptr),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   // Address fields come from the source being picked now; beat fields from the
   // source already holding the grant.
   always_comb begin
      req_ip    = '0;
      req_port  = '0;
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_eof   = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (rr_grant[i]) begin
            req_ip   = src_dest_ip[IP_W*i +: IP_W];
            req_port = src_dest_port[PORT_W*i +: PORT_W];
         end
         if (grant_id == IDX_W'(i)) begin
            sel_data  = src_data[WORD_W*i +: WORD_W];
            sel_valid = src_valid[i];
            sel_eof   = src_eof[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      src_ready  = '0;
      accept     = 1'b0;
      grant_now  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!tx_afull && (req != '0)) begin
               grant_now  = 1'b1;
               next_state = ST_SEND;
            end
         end
         ST_SEND: begin
            for (int i = 0; i < N_SRC; i++) src_ready[i] = (grant_id == IDX_W'(i));
            accept = sel_valid;
            if (sel_valid && sel_eof)
               next_state = (gap_cycles != '0) ? ST_GAP : ST_IDLE;
         end
         ST_GAP: begin
            if (gap_next == gap_cycles) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         tx_eof       <= 1'b0;
         tx_dest_ip   <= '0;
         tx_dest_port <= '0;
         grant_id     <= '0;
         ptr          <= IDX_W'(N_SRC - 1);
         gap_cnt      <= '0;
         pkt_count    <= '0;
      end else begin
         tx_valid <= accept;
         tx_eof   <= accept & sel_eof;
         if (accept) tx_data <= sel_data;
         if (grant_now) begin
            grant_id     <= rr_idx;
            ptr          <= rr_idx;
            tx_dest_ip   <= req_ip;
            tx_dest_port <= req_port;
         end
         gap_cnt <= (state == ST_GAP) ? gap_next : '0;
         if (tx_valid && tx_eof) pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_tge_tx_arbiter.sv
// Directed bench for tge_tx_arbiter: arbitration order table, gap table, and corner sequences.
module tb_tge_tx_arbiter;
   localparam int N  = 4;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*64-1:0] src_data;
   logic [N-1:0]    src_valid, src_eof, src_ready, src_enable;
   logic [N*32-1:0] src_dest_ip;
   logic [N*16-1:0] src_dest_port;
   logic [CW-1:0]   gap_cycles;
   logic            tx_afull;
   logic [63:0]     tx_data;
   logic            tx_valid, tx_eof;
   logic [31:0]     tx_dest_ip;
   logic [15:0]     tx_dest_port;
   logic [2:0]      grant_id;
   logic [CW-1:0]   pkt_count;
   logic [1:0]      fsm_state;

   tge_tx_arbiter #(.N_SRC(N), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .src_eof(src_eof),
      .src_dest_ip(src_dest_ip), .src_dest_port(src_dest_port), .src_ready(src_ready),
      .src_enable(src_enable), .gap_cycles(gap_cycles), .tx_afull(tx_afull),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_eof(tx_eof), .tx_dest_ip(tx_dest_ip),
      .tx_dest_port(tx_dest_port), .grant_id(grant_id), .pkt_count(pkt_count),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [N-1:0] valid_mask;
   int          pkt_len;
   logic [31:0] ip_arr [N];
   int          beat_cnt [N];
   int          pkt_cnt [N];
   logic [64:0] exp_q [$];
   int          eof_src [$];

   typedef struct {
      logic [3:0]      en;
      logic [3:0]      vm;
      int              len;
      int              gap;
      logic [3:0][2:0] order;
   } arb_vec_t;
   arb_vec_t vecs [5];

   typedef struct {
      int gap;
      int idle;
   } gap_vec_t;
   gap_vec_t gvecs [3];

   function automatic logic [31:0] ip_base(int s);
      return 32'h0A000001 + 32'(s << 8);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         src_valid[i] = valid_mask[i];
         src_eof[i]   = (beat_cnt[i] == pkt_len - 1);
         src_data[64*i +: 64]    = {8'(i), 8'(pkt_cnt[i]), 8'(beat_cnt[i]), 40'h0};
         src_dest_ip[32*i +: 32] = ip_arr[i];
         src_dest_port[16*i +: 16] = 16'(1000 + i);
      end
   endtask

   task automatic observe();
      logic [64:0] e;
      int s;
      if (tx_valid) begin
         s = int'(tx_data[63:56]);
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got beat %0h want none", tx_data);
         end else begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e[63:0]);
            check("tx_eof", 64'(tx_eof), 64'(e[64]));
         end
         check("tx_dest_ip", 64'(tx_dest_ip), 64'(ip_base(s)));
         check("tx_dest_port", 64'(tx_dest_port), 64'(16'(1000 + s)));
         if (tx_eof) eof_src.push_back(s);
      end else begin
         check("tx_eof_idle", 64'(tx_eof), 64'(0));
      end
   endtask

   // Called at a negedge; returns at the next negedge with outputs checked.
   task automatic step();
      logic [N-1:0] acc;
      drive_inputs();
      acc = '0;
      check("ready_onehot", 64'($onehot0(src_ready)), 64'(1));
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            if (src_valid[i] && src_ready[i]) begin
               acc[i] = 1'b1;
               exp_q.push_back({src_eof[i], src_data[64*i +: 64]});
            end
         end
      end
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            if (beat_cnt[i] == pkt_len - 1) begin
               beat_cnt[i] = 0;
               pkt_cnt[i]++;
            end else begin
               beat_cnt[i]++;
            end
         end
      end
      @(negedge clk);
      observe();
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      valid_mask = '0;
      tx_afull   = 1'b0;
      src_enable = 4'b1111;
      gap_cycles = '0;
      pkt_len    = 1;
      for (int i = 0; i < N; i++) begin
         beat_cnt[i] = 0;
         pkt_cnt[i]  = 0;
         ip_arr[i]   = ip_base(i);
      end
      drive_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      eof_src.delete();
   endtask

   task automatic run_until_eofs(int n, string name);
      int cyc;
      cyc = 0;
      while (eof_src.size() < n && cyc < 300) begin
         step();
         cyc++;
      end
      if (eof_src.size() < n) begin
         total++; bad++;
         $display("FAIL %s_timeout: got %0d eof beats want %0d", name, eof_src.size(), n);
      end
   endtask

   initial begin
      int cyc, idle;
      vecs[0] = '{4'b1111, 4'b0101, 3, 0, {3'd2, 3'd0, 3'd2, 3'd0}};
      vecs[1] = '{4'b1011, 4'b1111, 1, 0, {3'd0, 3'd3, 3'd1, 3'd0}};
      vecs[2] = '{4'b1111, 4'b1111, 2, 2, {3'd3, 3'd2, 3'd1, 3'd0}};
      vecs[3] = '{4'b1110, 4'b1001, 1, 1, {3'd3, 3'd3, 3'd3, 3'd3}};
      vecs[4] = '{4'b1111, 4'b0110, 4, 0, {3'd2, 3'd1, 3'd2, 3'd1}};
      gvecs[0] = '{3, 3};
      gvecs[1] = '{0, 0};
      gvecs[2] = '{1, 1};

      // Reset state while rst is held low
      rst = 1'b0; valid_mask = '0; tx_afull = 1'b0; src_enable = '1; gap_cycles = '0; pkt_len = 1;
      for (int i = 0; i < N; i++) begin beat_cnt[i] = 0; pkt_cnt[i] = 0; ip_arr[i] = ip_base(i); end
      drive_inputs();
      repeat (3) @(negedge clk);
      check("rst_tx_valid", 64'(tx_valid), 64'(0));
      check("rst_tx_eof", 64'(tx_eof), 64'(0));
      check("rst_tx_data", tx_data, 64'(0));
      check("rst_ready", 64'(src_ready), 64'(0));
      check("rst_grant_id", 64'(grant_id), 64'(0));
      check("rst_pkt_count", 64'(pkt_count), 64'(0));
      check("rst_dest_ip", 64'(tx_dest_ip), 64'(0));
      check("rst_dest_port", 64'(tx_dest_port), 64'(0));
      check("rst_state", 64'(fsm_state), 64'(0));

      // Arbitration order table
      for (int v = 0; v < 5; v++) begin
         do_reset();
         src_enable = vecs[v].en;
         valid_mask = vecs[v].vm;
         pkt_len    = vecs[v].len;
         gap_cycles = CW'(vecs[v].gap);
         run_until_eofs(4, "order");
         valid_mask = '0;
         step();
         check("order_pkt_count", 64'(pkt_count), 64'(4));
         for (int k = 0; k < 4; k++) begin
            if (k < eof_src.size())
               check("order_src", 64'(eof_src[k]), 64'(vecs[v].order[k]));
         end
      end

      // Gap length table: idle tx cycles between tx_eof and the next src_ready
      for (int g = 0; g < 3; g++) begin
         do_reset();
         valid_mask = 4'b0010;
         pkt_len    = 5;
         gap_cycles = CW'(gvecs[g].gap);
         run_until_eofs(1, "gap");
         idle = 0;
         cyc  = 0;
         while (cyc < 50) begin
            step();
            cyc++;
            if (src_ready[1]) break;
            if (!tx_valid) idle++;
         end
         check("gap_idle_cycles", 64'(idle), 64'(gvecs[g].idle));
      end

      // tx_afull blocks new packets but not one in flight
      do_reset();
      valid_mask = 4'b1111;
      pkt_len    = 2;
      tx_afull   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("afull_no_ready", 64'(src_ready), 64'(0));
      end
      tx_afull = 1'b0;
      step();
      check("afull_drop_grant", 64'(src_ready), 64'(4'b0001));
      tx_afull = 1'b1;
      step();
      check("afull_first_beat", 64'(tx_valid), 64'(1));
      repeat (2) step();
      check("afull_pkt_done", 64'(eof_src.size()), 64'(1));
      check("afull_no_regrant", 64'(src_ready), 64'(0));
      tx_afull = 1'b0;

      // Destination IP changes mid-packet are not picked up
      do_reset();
      valid_mask = 4'b0001;
      pkt_len    = 4;
      cyc = 0;
      while (beat_cnt[0] == 0 && cyc < 20) begin step(); cyc++; end
      check("ip_first_beat_taken", 64'(beat_cnt[0]), 64'(1));
      ip_arr[0] = 32'h0A000002;
      run_until_eofs(1, "ip");
      valid_mask = '0;
      check("ip_hold_at_eof", 64'(tx_dest_ip), 64'(32'h0A000001));
      step();

      // Reset during the second beat of a 4-beat packet
      do_reset();
      valid_mask = 4'b0010;
      pkt_len    = 4;
      run_until_eofs(1, "abort_pre");
      cyc = 0;
      while (beat_cnt[1] == 0 && cyc < 20) begin step(); cyc++; end
      check("abort_pkt_count_pre", 64'(pkt_count), 64'(1));
      check("abort_grant_pre", 64'(grant_id), 64'(1));
      rst = 1'b0;
      step();
      check("abort_tx_valid", 64'(tx_valid), 64'(0));
      check("abort_tx_eof", 64'(tx_eof), 64'(0));
      check("abort_pkt_count", 64'(pkt_count), 64'(0));
      check("abort_grant_id", 64'(grant_id), 64'(0));
      check("abort_ready", 64'(src_ready), 64'(0));
      rst = 1'b1;
      exp_q.delete();
      eof_src.delete();
      valid_mask = '0;
      for (int i = 0; i < N; i++) beat_cnt[i] = 0;
      repeat (3) step();
      check("abort_no_eof", 64'(pkt_count), 64'(0));
      valid_mask = 4'b0010;
      step();
      check("post_rst_grant", 64'(src_ready), 64'(4'b0010));
      run_until_eofs(1, "post_rst");
      valid_mask = '0;
      step();
      check("post_rst_pkt_count", 64'(pkt_count), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tge_tx_arbiter.md
TGE_TX_ARBITER -- requirements
Module: tge_tx_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, number of packet sources sharing one TGE transmit port (2..8).
REQ-002 Parameter CNT_WIDTH, default 32, width of the gap and statistics counters.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 src_data  input  N_SRC*64  per-source 64-bit beat; source i occupies bits [64*i+63:64*i].
REQ-006 src_valid  input  N_SRC  per-source beat valid; also serves as the packet request.
REQ-007 src_eof  input  N_SRC  per-source last beat of packet, qualified by src_valid.
REQ-008 src_dest_ip  input  N_SRC*32  per-source destination IP.
REQ-009 src_dest_port  input  N_SRC*16  per-source destination port.
REQ-010 src_ready  output  N_SRC  per-source beat accept; a beat transfers when src_valid and src_ready are both high.
REQ-011 src_enable  input  N_SRC  per-source arbitration mask; 0 excludes the source from new grants.
REQ-012 gap_cycles  input  CNT_WIDTH  idle cycles inserted after each packet.
REQ-013 tx_afull  input  1  TGE almost-full; blocks the start of new packets.
REQ-014 tx_data  output  64; tx_valid  output  1; tx_eof  output  1; tx_dest_ip  output  32; tx_dest_port  output  16 -- TGE transmit side.
REQ-015 grant_id  output  3  index of the currently or most recently granted source.
REQ-016 pkt_count  output  CNT_WIDTH  packets sent (tx_eof beats), wraps modulo 2^CNT_WIDTH.

Function
REQ-017 FSM states: IDLE, SEND, GAP.
REQ-018 IDLE: when tx_afull=0 and (src_valid & src_enable) != 0, select one source round-robin, latch its index, dest_ip and dest_port, and enter SEND on the next cycle.
REQ-019 Round-robin: search begins at (last granted index + 1) mod N_SRC; after reset it begins at index 0.
REQ-020 IDLE with tx_afull=1 or no enabled request: remain in IDLE, no grant.
REQ-021 src_ready[i] = 1 only in SEND with grant_id=i; 0 for all other sources and states.
REQ-022 SEND: each accepted beat appears on tx_data/tx_valid/tx_eof exactly one cycle later (registered, latency 1); cycles without an accepted beat drive tx_valid=0 and tx_eof=0.
REQ-023 tx_dest_ip/tx_dest_port hold the values latched at grant for the whole packet; source changes mid-packet are ignored.
REQ-024 SEND ends on the accepted beat with src_eof=1: enter GAP if gap_cycles!=0, else IDLE.
REQ-025 tx_afull and src_enable changes during SEND do not interrupt the packet in flight.
REQ-026 GAP: count gap_cycles cycles with tx_valid=0, then enter IDLE; gap counter compares on equality, full CNT_WIDTH width.
REQ-027 A single-beat packet (src_valid and src_eof in the first SEND cycle) is legal: one tx beat with tx_eof=1.
REQ-028 pkt_count increments by 1 on every cycle where tx_valid and tx_eof are both 1.
REQ-029 Minimum cost per packet: 1 IDLE cycle + beats + gap_cycles.

Reset
REQ-030 While rst=0: state=IDLE, src_ready=0, tx_valid=0, tx_eof=0, tx_data=0, tx_dest_ip=0, tx_dest_port=0, grant_id=0, pkt_count=0, gap counter=0, round-robin pointer so the next search starts at 0.
REQ-031 Reset asserted mid-packet aborts the packet without emitting tx_eof; the first post-reset packet starts from IDLE.

Structure
REQ-032 A shared package holds the FSM state encoding constants (IDLE, SEND, GAP) and the TGE word/IP/port width constants.
REQ-033 The round-robin selector is a separate sub-module, rr_select: inputs request vector and last index, output one-hot grant and index, purely combinational.

Verification
REQ-034 Sources 0 and 2 each send 3-beat packets continuously, gap_cycles=0 -> tx order alternates src0, src2, src0, src2; pkt_count=4 after four eof beats.
REQ-035 Source 1 sends a 5-beat packet, gap_cycles=3 -> exactly 3 tx_valid=0 cycles after tx_eof before source 1's next grant cycle.
REQ-036 tx_afull=1 while all sources request -> no src_ready asserted; tx_afull dropped -> grant within 1 cycle and first tx beat 2 cycles later.
REQ-037 src_dest_ip changed from 0x0A000001 to 0x0A000002 mid-packet -> tx_dest_ip stays 0x0A000001 until the packet's tx_eof.
REQ-038 src_enable=4'b1011 with all sources requesting -> source 2 is never granted; grants cycle 0, 1, 3.
REQ-039 rst pulled low during beat 2 of a 4-beat packet -> next cycle tx_valid=0, pkt_count=0, grant_id=0; no tx_eof emitted for the aborted packet.
